// File: rtl/sim_clock_monitor_pkg.sv
// Shared types for sim_clock_monitor: monitor FSM states and the period tolerance test.
// No logic state lives here; everything is combinational.
package sim_clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } mon_state_t;

    // A saturated counter means the period overflowed, which can never be good.
    function automatic logic period_in_tol(input logic [31:0] per,
                                           input logic [31:0] exp_per,
                                           input logic [31:0] tol,
                                           input logic        sat);
        logic [31:0] lo_lim;
        lo_lim = (exp_per > tol) ? exp_per - tol : 32'd0;
        return !sat && (per >= lo_lim) && (per <= exp_per + tol);
    endfunction

endpackage

// File: rtl/sim_clock_monitor_sync.sv
// Brings clk_in into the sys_clk domain (2-FF sync + delay flop) and flags rising edges.
// rise appears 2-3 cycles after the raw edge; no backpressure.
module sim_clock_monitor_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise,
    output logic level
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise  = s2 & ~s3;
    assign level = s2;

endmodule

// File: rtl/sim_clock_monitor.sv
// Measures clk_in periods in sys_clk cycles, tracks lock and flags errors; duty counter under SIM_CLOCK_MONITOR_DUTY_EN.
// Outputs update one cycle after the detected rise; pure monitor, no backpressure.
module sim_clock_monitor
    import sim_clock_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = 16,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    input  logic             enable,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             err,
    output logic [31:0]      edge_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(EXP_PERIOD + TOL + 1);

    logic             rise;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good_cnt;
    mon_state_t       state;
    mon_state_t       state_nxt;
    logic             cnt_sat;
    logic             good;
    logic             stall;
    logic             capture;
    logic             good_inc;
    logic             good_clr;
    logic             err_set;

    sim_clock_monitor_sync u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .raw   (clk_in),
        .rise  (rise),
        .level (level)
    );

    assign cnt_sat = &cnt;
    assign good    = period_in_tol(32'(cnt), 32'(EXP_PERIOD), 32'(TOL), cnt_sat);
    // A rise in the same cycle as the limit is a (bad) period, not a stall.
    assign stall   = !rise && (cnt >= TIMEOUT);
    assign locked  = (state == ST_LOCKED);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        good_inc  = 1'b0;
        good_clr  = 1'b0;
        err_set   = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            good_clr  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ARM;
                    good_clr  = 1'b1;
                end
                ST_ARM: begin
                    if (rise) state_nxt = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (rise) begin
                        capture = 1'b1;
                        if (good) begin
                            good_inc = 1'b1;
                            if (good_cnt == GW'(LOCK_COUNT - 1)) state_nxt = ST_LOCKED;
                        end else begin
                            good_clr = 1'b1;
                        end
                    end else if (stall) begin
                        state_nxt = ST_ARM;
                        good_clr  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        capture = 1'b1;
                        if (!good) begin
                            err_set   = 1'b1;
                            good_clr  = 1'b1;
                            state_nxt = ST_MEASURE;
                        end
                    end else if (stall) begin
                        err_set   = 1'b1;
                        good_clr  = 1'b1;
                        state_nxt = ST_ARM;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt          <= '0;
            good_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            err          <= 1'b0;
            edge_count   <= '0;
        end else begin
            period_valid <= capture;
            if (capture) period <= cnt;
            if (state != ST_IDLE) begin
                if (rise)          cnt <= CNT_W'(1);
                else if (!cnt_sat) cnt <= cnt + CNT_W'(1);
            end
            if (good_clr)      good_cnt <= '0;
            else if (good_inc) good_cnt <= good_cnt + GW'(1);
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            if (enable && rise) edge_count <= edge_count + 32'd1;
        end
    end

`ifdef SIM_CLOCK_MONITOR_DUTY_EN
    logic [CNT_W-1:0] hcnt;

    // The rise cycle is itself a high sample, so the count restarts at 1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            if (state != ST_IDLE) begin
                if (rise)                    hcnt <= CNT_W'(1);
                else if (level && !(&hcnt)) hcnt <= hcnt + CNT_W'(1);
            end
            if (capture) high_time <= hcnt;
        end
    end
`else
    wire unused_level = level;
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_sim_clock_monitor.sv
// Self-checking bench for sim_clock_monitor: scripted clk_in waveforms compared against an event-level reference model.
module tb_sim_clock_monitor;

    localparam int EXP  = 16;
    localparam int TOL  = 1;
    localparam int LCK  = 4;
    localparam int CW   = 16;
    localparam int MAXC = 1600;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          clk_in;
    logic          enable;
    logic          err_clr;
    logic [CW-1:0] period;
    logic          period_valid;
    logic [CW-1:0] high_time;
    logic          locked;
    logic          err;
    logic [31:0]   edge_count;

    sim_clock_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .LOCK_COUNT(LCK), .CNT_W(CW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .clk_in       (clk_in),
        .enable       (enable),
        .err_clr      (err_clr),
        .period       (period),
        .period_valid (period_valid),
        .high_time    (high_time),
        .locked       (locked),
        .err          (err),
        .edge_count   (edge_count)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    // Stimulus per cycle, observed and expected outputs per sample point.
    logic          w_clk [MAXC];
    logic          w_en  [MAXC];
    logic          w_clr [MAXC];
    int            wp;
    int            rises[$];
    logic          o_pv [MAXC], e_pv [MAXC];
    logic          o_lk [MAXC], e_lk [MAXC];
    logic          o_er [MAXC], e_er [MAXC];
    logic [CW-1:0] o_per[MAXC], e_per[MAXC];
    logic [CW-1:0] o_ht [MAXC], e_ht [MAXC];
    logic [31:0]   o_ec [MAXC], e_ec [MAXC];

    task automatic new_wave();
        wp = 0;
        rises.delete();
        for (int i = 0; i < MAXC; i++) begin
            w_clk[i] = 1'b0;
            w_en[i]  = 1'b1;
            w_clr[i] = 1'b0;
        end
    endtask

    task automatic pad(input int n);
        wp = wp + n;
    endtask

    // One clk_in period: rises at the current position, hi cycles high then lo low.
    task automatic seg(input int hi, input int lo);
        rises.push_back(wp);
        for (int i = 0; i < hi; i++) begin
            if (wp < MAXC) w_clk[wp] = 1'b1;
            wp++;
        end
        wp = wp + lo;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        clk_in    = 1'b0;
        enable    = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Sample outputs at each falling edge, then apply that cycle's inputs.
    task automatic play(input int n);
        for (int k = 0; k <= n; k++) begin
            @(negedge sys_clk);
            o_pv[k]  = period_valid;
            o_lk[k]  = locked;
            o_er[k]  = err;
            o_per[k] = period;
            o_ht[k]  = high_time;
            o_ec[k]  = edge_count;
            if (k < n) begin
                clk_in  = w_clk[k];
                enable  = w_en[k];
                err_clr = w_clr[k];
            end
        end
        clk_in  = 1'b0;
        enable  = 1'b0;
        err_clr = 1'b0;
    endtask

    // Reference: walks detected rises and gaps between them. A clk_in edge driven in
    // cycle d is seen as a rise in cycle d+2; results of cycle c show at sample c+1.
    task automatic run_model(input int n);
        int            mode;     // 0 off, 1 waiting for first edge, 2 measuring, 3 locked
        int            mode0;
        int            last;
        int            run;
        int            gap;
        logic          er;
        logic [31:0]   ec;
        logic [CW-1:0] per;
        logic [CW-1:0] ht;
        logic          s2, s3, rise, pv, set, good;
        mode = 0; last = 0; run = 0; er = 1'b0; ec = '0; per = '0; ht = '0;
        e_pv[0] = 1'b0; e_lk[0] = 1'b0; e_er[0] = 1'b0;
        e_per[0] = '0; e_ht[0] = '0; e_ec[0] = '0;
        for (int c = 0; c < n; c++) begin
            s2   = (c >= 2) ? w_clk[c-2] : 1'b0;
            s3   = (c >= 3) ? w_clk[c-3] : 1'b0;
            rise = s2 && !s3;
            pv   = 1'b0;
            set  = 1'b0;
            gap  = c - last;
            mode0 = mode;
            if (!w_en[c]) begin
                mode = 0;
                run  = 0;
            end else if (mode == 0) begin
                mode = 1;
                run  = 0;
            end else if (mode == 1) begin
                if (rise) mode = 2;
            end else if (rise) begin
                pv   = 1'b1;
                per  = CW'(gap);
                good = (gap >= EXP - TOL) && (gap <= EXP + TOL);
`ifdef SIM_CLOCK_MONITOR_DUTY_EN
                ht = '0;
                for (int j = last; j < c; j++) if (j >= 2 && w_clk[j-2]) ht = ht + CW'(1);
`endif
                if (mode == 2) begin
                    if (good) begin
                        run++;
                        if (run == LCK) mode = 3;
                    end else begin
                        run = 0;
                    end
                end else if (!good) begin
                    set  = 1'b1;
                    run  = 0;
                    mode = 2;
                end
            end else if (gap >= EXP + TOL + 1) begin
                if (mode == 3) set = 1'b1;
                mode = 1;
                run  = 0;
            end
            if (rise && mode0 != 0) last = c;
            if (set)           er = 1'b1;
            else if (w_clr[c]) er = 1'b0;
            if (w_en[c] && rise) ec = ec + 32'd1;
            e_pv[c+1]  = pv;
            e_lk[c+1]  = (mode == 3);
            e_er[c+1]  = er;
            e_per[c+1] = per;
            e_ht[c+1]  = ht;
            e_ec[c+1]  = ec;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge sys_clk);
        tests++; if (period !== '0)        begin fails++; $display("FAIL reset_period got %0d want 0", period); end
        tests++; if (period_valid !== 1'b0) begin fails++; $display("FAIL reset_period_valid got %b want 0", period_valid); end
        tests++; if (high_time !== '0)     begin fails++; $display("FAIL reset_high_time got %0d want 0", high_time); end
        tests++; if (locked !== 1'b0)      begin fails++; $display("FAIL reset_locked got %b want 0", locked); end
        tests++; if (err !== 1'b0)         begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (edge_count !== '0)    begin fails++; $display("FAIL reset_edge_count got %0d want 0", edge_count); end
    endtask

    task automatic test_nominal();
        int n, np, first, last_p;
        new_wave();
        pad($urandom_range(3, 8));
        for (int i = 0; i < 9; i++) begin
            int h;
            h = $urandom_range(2, 14);
            seg(h, 16 - h);
        end
        n = wp + 25;
        do_reset(); run_model(n); play(n);
        np = 0; first = -1; last_p = 0;
        for (int k = 0; k <= n; k++) begin
            if (o_pv[k]) begin
                np++;
                if (first < 0) first = k;
                last_p = k;
                tests++; if (o_per[k] !== 16) begin fails++; $display("FAIL nominal_period pulse %0d got %0d want 16", np, o_per[k]); end
                tests++; if (o_lk[k] !== (np >= 4)) begin fails++; $display("FAIL nominal_locked pulse %0d got %b want %b", np, o_lk[k], np >= 4); end
            end
        end
        tests++; if (np !== 8) begin fails++; $display("FAIL nominal_pulse_count got %0d want 8", np); end
        tests++; if (first !== rises[1] + 3) begin fails++; $display("FAIL nominal_first_pulse got %0d want %0d", first, rises[1] + 3); end
        tests++; if (o_er[last_p] !== 1'b0) begin fails++; $display("FAIL nominal_err got %b want 0", o_er[last_p]); end
        tests++; if (o_ec[last_p] !== 32'd9) begin fails++; $display("FAIL nominal_edge_count got %0d want 9", o_ec[last_p]); end
    endtask

    task automatic test_alternate();
        int n, np;
        new_wave();
        pad(5);
        for (int i = 0; i < 8; i++) begin
            int p;
            p = (i % 2 == 0) ? 15 : 17;
            seg($urandom_range(2, p - 2), 0);
            wp = rises[rises.size()-1] + p;
        end
        n = wp + 10;
        do_reset(); run_model(n); play(n);
        np = 0;
        for (int k = 0; k <= n; k++) begin
            if (o_pv[k]) begin
                np++;
                tests++; if (o_per[k] !== e_per[k]) begin fails++; $display("FAIL alt_period pulse %0d got %0d want %0d", np, o_per[k], e_per[k]); end
                tests++; if (o_lk[k] !== (np >= 4)) begin fails++; $display("FAIL alt_locked pulse %0d got %b want %b", np, o_lk[k], np >= 4); end
            end
        end
        tests++; if (np !== 7) begin fails++; $display("FAIL alt_pulse_count got %0d want 7", np); end

        new_wave();
        pad(4);
        for (int i = 0; i < 8; i++) seg(9, 9);
        n = wp + 30;
        do_reset(); run_model(n); play(n);
        np = 0;
        for (int k = 0; k <= n; k++) begin
            if (o_pv[k]) begin
                np++;
                tests++; if (o_per[k] !== 18) begin fails++; $display("FAIL slow_period pulse %0d got %0d want 18", np, o_per[k]); end
            end
            tests++; if (o_lk[k] !== 1'b0 || o_er[k] !== 1'b0) begin
                fails++; $display("FAIL slow_lock_err sample %0d got locked=%b err=%b want 0/0", k, o_lk[k], o_er[k]);
            end
        end
        tests++; if (np !== 7) begin fails++; $display("FAIL slow_pulse_count got %0d want 7", np); end
    endtask

    task automatic test_bad_after_lock();
        int n, b;
        new_wave();
        pad(4);
        for (int i = 0; i < 6; i++) seg(8, 8);
        seg(6, 7);
        for (int i = 0; i < 5; i++) seg(8, 8);
        w_clr[rises[7] + 2] = 1'b1;
        w_clr[rises[9]]     = 1'b1;
        n = wp + 10;
        do_reset(); run_model(n); play(n);
        b = rises[7] + 3;
        tests++; if (o_pv[b] !== 1'b1 || o_per[b] !== 13) begin fails++; $display("FAIL bad_pulse got pv=%b period=%0d want 1/13", o_pv[b], o_per[b]); end
        tests++; if (o_lk[b-1] !== 1'b1 || o_lk[b] !== 1'b0) begin fails++; $display("FAIL bad_locked got %b->%b want 1->0", o_lk[b-1], o_lk[b]); end
        tests++; if (o_er[b-1] !== 1'b0 || o_er[b] !== 1'b1) begin fails++; $display("FAIL bad_err_set_wins got %b->%b want 0->1", o_er[b-1], o_er[b]); end
        tests++; if (o_er[rises[9]] !== 1'b1 || o_er[rises[9]+1] !== 1'b0) begin
            fails++; $display("FAIL err_clear got %b->%b want 1->0", o_er[rises[9]], o_er[rises[9]+1]);
        end
        tests++; if (o_lk[rises[10]+3] !== 1'b0 || o_lk[rises[11]+3] !== 1'b1) begin
            fails++; $display("FAIL relock got %b,%b want 0,1", o_lk[rises[10]+3], o_lk[rises[11]+3]);
        end
        for (int k = 0; k <= n; k++) begin
            tests++; if (o_er[k] !== e_er[k] || o_lk[k] !== e_lk[k]) begin
                fails++; $display("FAIL bad_model sample %0d got err=%b locked=%b want %b/%b", k, o_er[k], o_lk[k], e_er[k], e_lk[k]);
            end
        end
    endtask

    task automatic test_stall();
        int n, d;
        new_wave();
        pad(6);
        for (int i = 0; i < 6; i++) seg(8, 8);
        seg(40, 8);
        seg(8, 8);
        seg(8, 8);
        n = wp + 5;
        do_reset(); run_model(n); play(n);
        d = rises[6];
        tests++; if (o_er[d+20] !== 1'b0 || o_er[d+21] !== 1'b1) begin fails++; $display("FAIL stall_err got %b->%b want 0->1", o_er[d+20], o_er[d+21]); end
        tests++; if (o_lk[d+20] !== 1'b1 || o_lk[d+21] !== 1'b0) begin fails++; $display("FAIL stall_locked got %b->%b want 1->0", o_lk[d+20], o_lk[d+21]); end
        tests++; if (o_pv[rises[7]+3] !== 1'b0) begin fails++; $display("FAIL stall_rearm_pulse got %b want 0", o_pv[rises[7]+3]); end
        tests++; if (o_pv[rises[8]+3] !== 1'b1 || o_per[rises[8]+3] !== 16) begin
            fails++; $display("FAIL stall_resume got pv=%b period=%0d want 1/16", o_pv[rises[8]+3], o_per[rises[8]+3]);
        end
    endtask

    task automatic test_enable_drop();
        int n, x;
        new_wave();
        pad(5);
        for (int i = 0; i < 12; i++) seg(7, 9);
        x = rises[6] + 5;
        for (int k = x; k < MAXC; k++) w_en[k] = 1'b0;
        n = wp + 10;
        do_reset(); run_model(n); play(n);
        tests++; if (o_lk[x] !== 1'b1 || o_lk[x+1] !== 1'b0) begin fails++; $display("FAIL en_drop_locked got %b->%b want 1->0", o_lk[x], o_lk[x+1]); end
        tests++; if (o_ec[n] !== 32'd7) begin fails++; $display("FAIL en_drop_edge_count got %0d want 7", o_ec[n]); end
        tests++; if (o_per[n] !== 16 || o_er[n] !== 1'b0) begin fails++; $display("FAIL en_drop_hold got period=%0d err=%b want 16/0", o_per[n], o_er[n]); end
        for (int k = x + 1; k <= n; k++) begin
            tests++; if (o_pv[k] !== 1'b0) begin fails++; $display("FAIL en_drop_pulse sample %0d got 1 want 0", k); end
        end
    endtask

    task automatic test_duty();
        int n, np;
        logic [CW-1:0] want;
`ifdef SIM_CLOCK_MONITOR_DUTY_EN
        want = CW'(4);
`else
        want = '0;
`endif
        new_wave();
        pad(3);
        for (int i = 0; i < 6; i++) seg(4, 12);
        n = wp + 5;
        do_reset(); run_model(n); play(n);
        np = 0;
        for (int k = 0; k <= n; k++) begin
            if (o_pv[k]) begin
                np++;
                tests++; if (o_ht[k] !== want) begin fails++; $display("FAIL duty_high_time pulse %0d got %0d want %0d", np, o_ht[k], want); end
            end
        end
        tests++; if (np !== 5) begin fails++; $display("FAIL duty_pulse_count got %0d want 5", np); end
    endtask

    task automatic test_random();
        int n, s, l;
        new_wave();
        pad($urandom_range(3, 10));
        for (int i = 0; i < 40; i++) begin
            int p;
            if ($urandom_range(0, 9) < 7) p = $urandom_range(15, 17);
            else begin
                case ($urandom_range(0, 5))
                    0:       p = 12;
                    1:       p = 13;
                    2:       p = 14;
                    3:       p = 18;
                    4:       p = 19;
                    default: p = 21;
                endcase
            end
            seg($urandom_range(2, p - 2), 0);
            wp = rises[rises.size()-1] + p;
        end
        n = wp + 30;
        for (int k = 0; k < n; k++) if ($urandom_range(0, 49) == 0) w_clr[k] = 1'b1;
        s = $urandom_range(100, n - 100);
        l = $urandom_range(5, 40);
        for (int k = s; k < s + l; k++) w_en[k] = 1'b0;
        do_reset(); run_model(n); play(n);
        for (int k = 0; k <= n; k++) begin
            tests++; if (o_pv[k]  !== e_pv[k])  begin fails++; $display("FAIL rnd_pv sample %0d got %b want %b", k, o_pv[k], e_pv[k]); end
            tests++; if (o_per[k] !== e_per[k]) begin fails++; $display("FAIL rnd_period sample %0d got %0d want %0d", k, o_per[k], e_per[k]); end
            tests++; if (o_lk[k]  !== e_lk[k])  begin fails++; $display("FAIL rnd_locked sample %0d got %b want %b", k, o_lk[k], e_lk[k]); end
            tests++; if (o_er[k]  !== e_er[k])  begin fails++; $display("FAIL rnd_err sample %0d got %b want %b", k, o_er[k], e_er[k]); end
            tests++; if (o_ec[k]  !== e_ec[k])  begin fails++; $display("FAIL rnd_edge_count sample %0d got %0d want %0d", k, o_ec[k], e_ec[k]); end
            tests++; if (o_ht[k]  !== e_ht[k])  begin fails++; $display("FAIL rnd_high_time sample %0d got %0d want %0d", k, o_ht[k], e_ht[k]); end
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        clk_in    = 1'b0;
        enable    = 1'b0;
        err_clr   = 1'b0;
        test_reset();
        test_nominal();
        test_alternate();
        test_bad_after_lock();
        test_stall();
        test_enable_drop();
        test_duty();
        test_random();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
